// File: rtl/aes_rx.sv
// Host-side receive framer for the AES-128 verify platform: turns a UART byte
// stream into 128-bit key / plaintext blocks with header, timeout and overrun checks.
module aes_rx #(
    parameter int          TIMEOUT  = 100000,
    parameter logic [7:0]  HDR_KEY  = 8'hA5,
    parameter logic [7:0]  HDR_DATA = 8'h5A
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     rx_byte,
    input  logic           rx_vld,
    output logic [127:0]   key_o,
    output logic           key_vld,
    output logic [127:0]   data_o,
    output logic           data_vld,
    input  logic           data_rdy,
    output logic           err_o,
    output logic [1:0]     err_code,
    output logic           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam int         GW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          isKey;
    logic [3:0]    count;
    logic [GW-1:0] gap;
    logic [127:0]  shreg;
    logic [127:0]  nextBlock;
    logic          takeHdr;

    // A byte is treated as a header in IDLE, or in HOLD when the handshake frees the slot this cycle.
    assign takeHdr   = rx_vld && ((state == IDLE) || ((state == HOLD) && data_rdy));
    assign nextBlock = {shreg[119:0], rx_byte};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            isKey    <= 1'b0;
            count    <= 4'd0;
            gap      <= '0;
            shreg    <= '0;
            key_o    <= '0;
            key_vld  <= 1'b0;
            data_o   <= '0;
            data_vld <= 1'b0;
            err_o    <= 1'b0;
            err_code <= 2'd0;
        end else begin
            key_vld <= 1'b0;
            err_o   <= 1'b0;

            case (state)
                RECV: begin
                    if (rx_vld) begin
                        shreg <= nextBlock;
                        count <= count + 4'd1;
                        gap   <= '0;
                        if (count == 4'd15) begin
                            if (isKey) begin
                                key_o   <= nextBlock;
                                key_vld <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                data_o   <= nextBlock;
                                data_vld <= 1'b1;
                                state    <= HOLD;
                            end
                        end
                    end else if (gap == GAP_LAST) begin
                        err_o    <= 1'b1;
                        err_code <= 2'd2;
                        state    <= IDLE;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                HOLD: begin
                    if (data_rdy) begin
                        data_vld <= 1'b0;
                        state    <= IDLE;
                    end else if (rx_vld) begin
                        err_o    <= 1'b1;
                        err_code <= 2'd3;
                    end
                end
                default: ;
            endcase

            // Header decode comes last so a header accepted during a handshake overrides the HOLD exit.
            if (takeHdr) begin
                if (rx_byte == HDR_KEY || rx_byte == HDR_DATA) begin
                    isKey <= (rx_byte == HDR_KEY);
                    count <= 4'd0;
                    gap   <= '0;
                    state <= RECV;
                end else begin
                    err_o    <= 1'b1;
                    err_code <= 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_rx.sv
// Self-checking bench for aes_rx: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based frame model.
module tb_aes_rx;

    localparam int TOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_byte;
    logic         rx_vld;
    logic [127:0] key_o;
    logic         key_vld;
    logic [127:0] data_o;
    logic         data_vld;
    logic         data_rdy;
    logic         err_o;
    logic [1:0]   err_code;
    logic         busy;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkOn     = 1'b0;

    aes_rx #(.TIMEOUT(TOUT), .HDR_KEY(8'hA5), .HDR_DATA(8'h5A)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_vld(rx_vld),
        .key_o(key_o), .key_vld(key_vld), .data_o(data_o), .data_vld(data_vld),
        .data_rdy(data_rdy), .err_o(err_o), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: collects payload bytes in a queue and decides outcomes per frame.
    logic [127:0] mKey, mData;
    logic         mKeyVld, mDataVld, mErr, mBusy;
    logic [1:0]   mCode;
    bit           mCollecting, mHolding, mIsKey;
    int           idleRun;
    logic [7:0]   frame[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            mKey = '0; mData = '0; mKeyVld = 0; mDataVld = 0; mErr = 0; mCode = 0;
            mCollecting = 0; mHolding = 0; mIsKey = 0; idleRun = 0;
            frame.delete();
        end else begin
            bit asHeader;
            logic [127:0] blk;
            asHeader = 0;
            mKeyVld  = 0;
            mErr     = 0;
            if (mHolding) begin
                if (data_rdy) begin
                    mHolding = 0;
                    mDataVld = 0;
                    asHeader = rx_vld;
                end else if (rx_vld) begin
                    mErr = 1; mCode = 3;
                end
            end else if (mCollecting) begin
                if (rx_vld) begin
                    frame.push_back(rx_byte);
                    idleRun = 0;
                    if (frame.size() == 16) begin
                        blk = '0;
                        foreach (frame[i]) blk = {blk[119:0], frame[i]};
                        if (mIsKey) begin
                            mKey = blk; mKeyVld = 1;
                        end else begin
                            mData = blk; mDataVld = 1; mHolding = 1;
                        end
                        mCollecting = 0;
                    end
                end else begin
                    idleRun++;
                    if (idleRun == TOUT) begin
                        mErr = 1; mCode = 2; mCollecting = 0;
                    end
                end
            end else begin
                asHeader = rx_vld;
            end
            if (asHeader) begin
                if (rx_byte == 8'hA5 || rx_byte == 8'h5A) begin
                    mIsKey = (rx_byte == 8'hA5);
                    mCollecting = 1;
                    idleRun = 0;
                    frame.delete();
                end else begin
                    mErr = 1; mCode = 1;
                end
            end
        end
        mBusy = mCollecting || mHolding;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model key_o", key_o, mKey);
            checkOutput("model key_vld", 128'(key_vld), 128'(mKeyVld));
            checkOutput("model data_o", data_o, mData);
            checkOutput("model data_vld", 128'(data_vld), 128'(mDataVld));
            checkOutput("model err_o", 128'(err_o), 128'(mErr));
            checkOutput("model err_code", 128'(err_code), 128'(mCode));
            checkOutput("model busy", 128'(busy), 128'(mBusy));
        end
    end

    // Drive one cycle of inputs; returns at the following negedge with outputs settled.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r);
        rx_vld   = v;
        rx_byte  = b;
        data_rdy = r;
        @(negedge clk);
    endtask

    task automatic sendPayload(input logic [127:0] payload);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, payload[127-8*i -: 8], 1'b0);
    endtask

    task automatic sendFrame(input logic [7:0] hdr, input logic [127:0] payload);
        applyStimulus(1'b1, hdr, 1'b0);
        sendPayload(payload);
    endtask

    logic [127:0] k1, k2, d1, d2, k3;
    int density;

    initial begin
        k1 = 128'h000102030405060708090A0B0C0D0E0F;
        d1 = {16{8'h3C}};
        k2 = 128'h112233445566778899AABBCCDDEEFF00;
        d2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
        k3 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

        rst_n = 1'b0; rx_vld = 1'b0; rx_byte = 8'h00; data_rdy = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOn = 1'b1;
        checkOutput("reset key_o", key_o, 128'h0);
        checkOutput("reset err_code", 128'(err_code), 128'h0);
        checkOutput("reset busy", 128'(busy), 128'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Key frame
        sendFrame(8'hA5, k1);
        checkOutput("key_vld after 16th byte", 128'(key_vld), 128'h1);
        checkOutput("key_o value", key_o, 128'h000102030405060708090A0B0C0D0E0F);
        checkOutput("data_vld during key frame", 128'(data_vld), 128'h0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("key_vld one cycle", 128'(key_vld), 128'h0);

        // Data frame with stall
        sendFrame(8'h5A, d1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("data_vld held in stall", 128'(data_vld), 128'h1);
        checkOutput("data_o value", data_o, {16{8'h3C}});
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("data_vld after handshake", 128'(data_vld), 128'h0);
        checkOutput("busy after handshake", 128'(busy), 128'h0);

        // Bad header then a good key frame
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("bad hdr err_o", 128'(err_o), 128'h1);
        checkOutput("bad hdr err_code", 128'(err_code), 128'h1);
        checkOutput("bad hdr busy", 128'(busy), 128'h0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("bad hdr err_o one cycle", 128'(err_o), 128'h0);
        sendFrame(8'hA5, k2);
        checkOutput("key after bad hdr", key_o, 128'h112233445566778899AABBCCDDEEFF00);

        // Timeout after 8 idle cycles
        applyStimulus(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < TOUT - 1; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("no timeout at 7 idle", 128'(err_o), 128'h0);
        checkOutput("busy at 7 idle", 128'(busy), 128'h1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("timeout err_o", 128'(err_o), 128'h1);
        checkOutput("timeout err_code", 128'(err_code), 128'h2);
        checkOutput("timeout busy", 128'(busy), 128'h0);
        checkOutput("timeout key_o kept", key_o, 128'h112233445566778899AABBCCDDEEFF00);

        // Byte on the 8th idle cycle wins
        applyStimulus(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h0F - 8'(i), 1'b0);
        for (int i = 0; i < TOUT - 1; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h69, 1'b0);
        checkOutput("late byte no err", 128'(err_o), 128'h0);
        checkOutput("late byte busy", 128'(busy), 128'h1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h78 + 8'h0F * 8'(i), 1'b0);
        checkOutput("late byte key_vld", 128'(key_vld), 128'h1);
        checkOutput("late byte key_o", key_o, 128'h0F0E0D0C0B69788796A5B4C3D2E1F0FF);

        // Overrun in HOLD, then handshake with a header in the same cycle
        sendFrame(8'h5A, d2);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("overrun err_o", 128'(err_o), 128'h1);
        checkOutput("overrun err_code", 128'(err_code), 128'h3);
        checkOutput("overrun data_o kept", data_o, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);
        checkOutput("overrun still holding", 128'(data_vld), 128'h1);
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("handshake+hdr data_vld", 128'(data_vld), 128'h0);
        checkOutput("handshake+hdr busy", 128'(busy), 128'h1);
        checkOutput("handshake+hdr no err", 128'(err_o), 128'h0);
        sendPayload(k3);
        checkOutput("key after overrun", key_o, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);

        // Reset in the middle of a data frame
        applyStimulus(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mid reset key_o", key_o, 128'h0);
        checkOutput("mid reset data_o", data_o, 128'h0);
        checkOutput("mid reset err_code", 128'(err_code), 128'h0);
        checkOutput("mid reset busy", 128'(busy), 128'h0);
        rst_n = 1'b1;
        sendFrame(8'h5A, d2);
        checkOutput("post reset data_o", data_o, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);
        checkOutput("post reset data_vld", 128'(data_vld), 128'h1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Randomized traffic with varying strobe density
        density = 90;
        for (int c = 0; c < 6000; c++) begin
            logic [7:0] b;
            int sel;
            if (c % 64 == 0) begin
                sel = $urandom_range(0, 2);
                density = (sel == 0) ? 95 : (sel == 1) ? 50 : 8;
            end
            sel = $urandom_range(0, 99);
            b = (sel < 20) ? 8'hA5 : (sel < 40) ? 8'h5A : 8'($urandom);
            rst_n = ($urandom_range(0, 999) != 0);
            applyStimulus(($urandom_range(0, 99) < density), b, ($urandom_range(0, 99) < 25));
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
